// File: rtl/apb_reg_bank.sv
// APB4 completer with a bank of NUM_REGS control/status registers.
// Software writes are byte-strobed and pulse wr_pulse_o; hardware can also update registers directly.
module apb_reg_bank #(
  parameter int                              ADDR_WIDTH  = 32,
  parameter int                              DATA_WIDTH  = 32,
  parameter int                              NUM_REGS    = 16,
  parameter int                              WAIT_CYCLES = 0,
  parameter logic [NUM_REGS-1:0]             RO_MASK     = '0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0]  RESET_VAL   = '0,
  parameter bit                              PRIV_ONLY   = 1'b0
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [ADDR_WIDTH-1:0]          paddr_i,
  input  logic [2:0]                     pprot_i,
  input  logic                           psel_i,
  input  logic                           penable_i,
  input  logic                           pwrite_i,
  input  logic [DATA_WIDTH-1:0]          pwdata_i,
  input  logic [DATA_WIDTH/8-1:0]        pstrb_i,
  output logic                           pready_o,
  output logic [DATA_WIDTH-1:0]          prdata_o,
  output logic                           pslverr_o,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q_o,
  input  logic [NUM_REGS-1:0]            hw_we_i,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_wdata_i,
  output logic [NUM_REGS-1:0]            wr_pulse_o
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_WIDTH - OFF_W;
  // Comparison width wide enough for both the captured index and NUM_REGS (up to 256).
  localparam int CW     = (IDX_W > 9) ? IDX_W : 9;

  typedef enum logic {IDLE, ACCESS} state_e;

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q;
  logic                   wr_q;
  logic [DATA_WIDTH-1:0]  wdata_q;
  logic [STRB_W-1:0]      strb_q;
  logic                   prot0_q;

  logic [DATA_WIDTH-1:0]  regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]  regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]    pulse_q;

  logic [NUM_REGS-1:0]    hit;
  logic [NUM_REGS-1:0]    we_vec;
  logic [DATA_WIDTH-1:0]  rd_data;
  logic                   setup;
  logic                   err;
  logic                   apb_we;
  logic                   unused_in;

  if (OFF_W > 0) begin : g_off
    assign unused_in = ^{pprot_i[2:1], paddr_i[OFF_W-1:0]};
  end else begin : g_nooff
    assign unused_in = ^pprot_i[2:1];
  end

  assign setup = psel_i & ~penable_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (setup) begin
          state_d = ACCESS;
          cnt_d   = 4'(WAIT_CYCLES);
        end
      end
      ACCESS: begin
        // Completion at cnt=0 is unconditional; a dropped psel only aborts during wait states.
        if (cnt_q == 4'd0)   state_d = IDLE;
        else if (!psel_i)    state_d = IDLE;
        else                 cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (state_q == IDLE && setup) begin
      idx_q   <= paddr_i[ADDR_WIDTH-1:OFF_W];
      wr_q    <= pwrite_i;
      wdata_q <= pwdata_i;
      strb_q  <= pstrb_i;
      prot0_q <= pprot_i[0];
    end
  end

  always_comb begin
    hit     = '0;
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      hit[i] = (CW'(idx_q) == CW'(i));
      if (hit[i]) rd_data = regs_q[i];
    end
  end

  assign pready_o  = (state_q == ACCESS) && (cnt_q == 4'd0);
  assign err       = (~|hit) | (wr_q & |(hit & RO_MASK)) | (PRIV_ONLY & ~prot0_q);
  assign pslverr_o = pready_o & err;
  assign prdata_o  = (pready_o && !err && !wr_q) ? rd_data : '0;
  assign apb_we    = pready_o & wr_q & ~err;
  assign we_vec    = hit & {NUM_REGS{apb_we}};

  // APB-strobed bytes win over a same-edge hardware write; other bytes follow hardware.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      for (int b = 0; b < STRB_W; b++) begin
        if (hw_we_i[i])
          regs_d[i][b*8 +: 8] = hw_wdata_i[i*DATA_WIDTH + b*8 +: 8];
        if (we_vec[i] && strb_q[b])
          regs_d[i][b*8 +: 8] = wdata_q[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs_q[i] <= RESET_VAL[i*DATA_WIDTH +: DATA_WIDTH];
      pulse_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++)
        regs_q[i] <= regs_d[i];
      pulse_q <= we_vec;
    end
  end

  always_comb begin
    reg_q_o = '0;
    for (int i = 0; i < NUM_REGS; i++)
      reg_q_o[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
  end

  assign wr_pulse_o = pulse_q;

endmodule

// File: tb/tb_apb_reg_bank.sv
// Self-checking bench for apb_reg_bank: three instances with different wait/privilege settings
// share one APB bus; expected responses are queued at drive time and popped on pready.
module tb_apb_reg_bank;

  localparam logic [511:0] RV = (512'hDEADBEEF << 96) | (512'h11223344 << 64);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] paddr, pwdata;
  logic [2:0]  pprot;
  logic        penable, pwrite;
  logic [3:0]  pstrb;
  logic [2:0]  psel, pready, pslverr;
  logic [31:0] prdata [3];
  logic [511:0] regq  [3];
  logic [15:0] pulse  [3];
  logic [15:0] hwwe   [3];
  logic [511:0] hwwd  [3];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  // Instance 0: no waits; 1: 3 waits + privileged only; 2: 2 waits.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int WC = (g == 0) ? 0 : ((g == 1) ? 3 : 2);
    apb_reg_bank #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .NUM_REGS   (16),
      .WAIT_CYCLES(WC),
      .RO_MASK    (16'h0002),
      .RESET_VAL  (RV),
      .PRIV_ONLY  (g == 1)
    ) u_dut (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .paddr_i   (paddr),
      .pprot_i   (pprot),
      .psel_i    (psel[g]),
      .penable_i (penable),
      .pwrite_i  (pwrite),
      .pwdata_i  (pwdata),
      .pstrb_i   (pstrb),
      .pready_o  (pready[g]),
      .prdata_o  (prdata[g]),
      .pslverr_o (pslverr[g]),
      .reg_q_o   (regq[g]),
      .hw_we_i   (hwwe[g]),
      .hw_wdata_i(hwwd[g]),
      .wr_pulse_o(pulse[g])
    );
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rg(input int d, input int i);
    return regq[d][i*32 +: 32];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that ends the pready cycle.
  task automatic apb(input int d, input logic [31:0] a, input logic w, input logic [31:0] wd,
                     input logic [3:0] st, input logic [2:0] pr,
                     input logic [31:0] erd, input logic eerr, input int ecyc);
    exp_t e;
    int   cyc;
    bit   done;
    e.rdata = erd; e.err = eerr; e.cyc = ecyc;
    sb.push_back(e);
    psel[d] = 1'b1; penable = 1'b0; paddr = a; pwrite = w; pwdata = wd; pstrb = st; pprot = pr;
    tick();
    penable = 1'b1;
    cyc  = 2;
    done = 1'b0;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      if (pready[d]) done = 1'b1;
      else begin
        tick();
        cyc++;
      end
    end
    e = sb.pop_front();
    if (done) begin
      chk("prdata", prdata[d], e.rdata);
      chk("pslverr", pslverr[d], e.err);
      chk("latency", cyc, e.cyc);
    end else begin
      chk("pready_timeout", pready[d], 1);
    end
    tick();
    psel[d] = 1'b0; penable = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    psel = '0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0; pstrb = '0; pprot = '0;
    for (int i = 0; i < 3; i++) begin
      hwwe[i] = '0;
      hwwd[i] = '0;
    end

    repeat (2) @(negedge clk);
    chk("rst_reg3", rg(0, 3), 32'hDEADBEEF);
    chk("rst_pready", pready[0], 0);
    chk("rst_pslverr", pslverr[0], 0);
    chk("rst_prdata", prdata[0], 0);
    chk("rst_pulse", pulse[0], 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Reset-value read followed back-to-back by a second read
    apb(0, 32'h0C, 0, 0, 4'hF, 3'b000, 32'hDEADBEEF, 0, 2);
    apb(0, 32'h08, 0, 0, 4'hF, 3'b000, 32'h11223344, 0, 2);

    // Byte-strobe write, zero wait
    apb(0, 32'h08, 1, 32'hAABBCCDD, 4'b0101, 3'b000, 0, 0, 2);
    @(negedge clk);
    chk("strb_reg2", rg(0, 2), 32'h11BB33DD);
    chk("strb_pulse", pulse[0], 16'h0004);
    @(negedge clk);
    chk("strb_pulse_once", pulse[0], 16'h0000);
    tick();

    // Byte-strobe write, three wait states (privileged)
    apb(1, 32'h08, 1, 32'hAABBCCDD, 4'b0101, 3'b001, 0, 0, 5);
    @(negedge clk);
    chk("w3_reg2", rg(1, 2), 32'h11BB33DD);
    chk("w3_pulse", pulse[1], 16'h0004);
    tick();

    // Out-of-range read and read-only write
    apb(0, 32'h40, 0, 0, 4'hF, 3'b000, 0, 1, 2);
    apb(0, 32'h04, 1, 32'hFFFFFFFF, 4'hF, 3'b000, 0, 1, 2);
    @(negedge clk);
    chk("ro_reg1", rg(0, 1), 0);
    chk("ro_pulse", pulse[0], 0);
    tick();

    // Privilege enforcement
    apb(1, 32'h00, 1, 32'hCAFEF00D, 4'hF, 3'b000, 0, 1, 5);
    @(negedge clk);
    chk("unpriv_reg0", rg(1, 0), 0);
    chk("unpriv_pulse", pulse[1], 0);
    tick();
    apb(1, 32'h00, 1, 32'hCAFEF00D, 4'hF, 3'b001, 0, 0, 5);
    @(negedge clk);
    chk("priv_reg0", rg(1, 0), 32'hCAFEF00D);
    chk("priv_pulse", pulse[1], 16'h0001);
    tick();

    // Zero-strobe write: OKAY, pulse, no data change
    apb(0, 32'h08, 1, 32'h0, 4'b0000, 3'b000, 0, 0, 2);
    @(negedge clk);
    chk("nostrb_reg2", rg(0, 2), 32'h11BB33DD);
    chk("nostrb_pulse", pulse[0], 16'h0004);
    tick();

    // APB / hardware collision on register 0
    hwwe[0] = 16'h0001;
    hwwd[0][31:0] = 32'h12345678;
    apb(0, 32'h00, 1, 32'h0000FFFF, 4'b0011, 3'b000, 0, 0, 2);
    hwwe[0] = '0;
    @(negedge clk);
    chk("collide_reg0", rg(0, 0), 32'h1234FFFF);
    tick();

    // Hardware write to a read-only register, then read it back
    hwwe[0] = 16'h0002;
    hwwd[0][63:32] = 32'hA5A5A5A5;
    tick();
    hwwe[0] = '0;
    apb(0, 32'h04, 0, 0, 4'hF, 3'b000, 32'hA5A5A5A5, 0, 2);

    // penable without a setup phase is ignored
    psel[0] = 1'b1; penable = 1'b1; paddr = 32'h0C; pwrite = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_penable", pready[0], 0);
      tick();
    end
    psel[0] = 1'b0; penable = 1'b0;
    tick();

    // Abort: psel dropped during wait states
    psel[2] = 1'b1; penable = 1'b0; paddr = 32'h00; pwrite = 1'b1; pwdata = 32'h77; pstrb = 4'hF;
    tick();
    penable = 1'b1;
    @(negedge clk);
    chk("abort_wait", pready[2], 0);
    tick();
    psel[2] = 1'b0; penable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_pready", pready[2], 0);
      chk("abort_pulse", pulse[2], 0);
      tick();
    end
    chk("abort_reg0", rg(2, 0), 0);

    // Asynchronous reset during ACCESS
    psel[2] = 1'b1; penable = 1'b0; paddr = 32'h0C; pwrite = 1'b1; pwdata = 32'h0; pstrb = 4'hF;
    tick();
    penable = 1'b1;
    tick();
    #1 rst_n = 1'b0;
    #1;
    chk("rstmid_pready", pready[2], 0);
    chk("rstmid_prdata", prdata[2], 0);
    chk("rstmid_reg3", rg(2, 3), 32'hDEADBEEF);
    chk("rstmid_a_reg2", rg(0, 2), 32'h11223344);
    chk("rstmid_a_reg0", rg(0, 0), 0);
    chk("rstmid_b_reg0", rg(1, 0), 0);
    psel[2] = 1'b0; penable = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Normal transfers after reset release
    apb(2, 32'h0C, 1, 32'hFEEDFACE, 4'hF, 3'b000, 0, 0, 4);
    @(negedge clk);
    chk("post_reg3", rg(2, 3), 32'hFEEDFACE);
    chk("post_pulse", pulse[2], 16'h0008);
    tick();
    apb(2, 32'h0C, 0, 0, 4'hF, 3'b000, 32'hFEEDFACE, 0, 4);

    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
